// File: rtl/dm_bytelane.sv
// dm_bytelane: single-port 32-bit data memory with byte/half/word access,
// sign/zero-extended loads, misalignment rejection, registered read data
// and an optional zeroing sweep after reset.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | zeroing one word per cycle, requests ignored (ready = 0)
// ST_IDLE  | accepting one access per cycle (ready = 1)
module dm_bytelane #(
  parameter int unsigned ADDR_W         = 10,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W+1:0] addr_i,
  input  logic [1:0]        size_i,
  input  logic              uns_i,
  input  logic [31:0]       wdata_i,
  output logic              ready_o,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              misalign_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              misalign_q, misalign_d;

  logic [31:0]       mem_q [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic              accept;
  logic              legal;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_val;
  logic [3:0]        be;
  logic [31:0]       wword;
  logic              mem_clr;
  logic              mem_st;

  assign idx     = addr_i[ADDR_W+1:2];
  assign lane    = addr_i[1:0];
  assign accept  = req_i & ready_q;
  assign rd_word = mem_q[idx];

  // Alignment rule: halves on even bytes, words on lane 0, size 11 never.
  always_comb begin
    legal = 1'b0;
    case (size_i)
      2'b00:   legal = 1'b1;
      2'b01:   legal = ~lane[0];
      2'b10:   legal = (lane == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  // Lane selection and extension of the addressed load data.
  always_comb begin
    rd_byte  = 8'h00;
    rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];
    load_val = rd_word;
    case (lane)
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    case (size_i)
      2'b00:   load_val = {{24{rd_byte[7] & ~uns_i}}, rd_byte};
      2'b01:   load_val = {{16{rd_half[15] & ~uns_i}}, rd_half};
      default: load_val = rd_word;
    endcase
  end

  // Store lane enables; data replicated so every enabled lane sees its bits.
  always_comb begin
    be    = 4'b1111;
    wword = wdata_i;
    case (size_i)
      2'b00: begin
        be    = 4'b0001 << lane;
        wword = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata_i[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wword = wdata_i;
      end
    endcase
  end

  // Next-state, clear sweep and access decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rvalid_d   = 1'b0;
    rdata_d    = 32'h0;
    misalign_d = 1'b0;
    mem_clr    = 1'b0;
    mem_st     = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        mem_clr = 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (accept) begin
          if (!legal) begin
            misalign_d = 1'b1;
          end else if (we_i) begin
            mem_st = 1'b1;
          end else begin
            rvalid_d = 1'b1;
            rdata_d  = load_val;
          end
        end
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

  // Storage array: not reset; written by the sweep or by lane-masked stores.
  always_ff @(posedge clk) begin
    if (mem_clr) begin
      mem_q[cnt_q] <= 32'h0;
    end else if (mem_st) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) begin
          mem_q[idx][8*k +: 8] <= wword[8*k +: 8];
        end
      end
    end
  end

  assign ready_o    = ready_q;
  assign rvalid_o   = rvalid_q;
  assign rdata_o    = rdata_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_dm_bytelane.sv
// Testbench for dm_bytelane (ADDR_W = 4, clear sweep enabled): directed
// vector table, randomized traffic against a byte-array reference model,
// and reset/clear-timing sequences.
module tb_dm_bytelane;

  localparam int AW    = 4;
  localparam int NBYTE = 4 * (2 ** AW);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [AW+1:0] addr = '0;
  logic [1:0]    size = 2'b00;
  logic          uns = 1'b0;
  logic [31:0]   wdata = 32'h0;
  logic          ready;
  logic          rvalid;
  logic [31:0]   rdata;
  logic          misalign;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  m_mem [NBYTE];
  logic        m_ready;
  logic        e_rv;
  logic [31:0] e_rd;
  logic        e_mis;

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic        x_rv;
    logic [31:0] x_rd;
    logic        x_mis;
  } vec_t;

  vec_t tbl [22];

  dm_bytelane #(.ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .we_i       (we),
    .addr_i     (addr),
    .size_i     (size),
    .uns_i      (uns),
    .wdata_i    (wdata),
    .ready_o    (ready),
    .rvalid_o   (rvalid),
    .rdata_o    (rdata),
    .misalign_o (misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NBYTE; i++) m_mem[i] = 8'h00;
  endtask

  // One bus cycle: drive at negedge, apply model at the edge, check at next negedge.
  task automatic step(input logic r, input logic w, input logic [5:0] a,
                      input logic [1:0] s, input logic u, input logic [31:0] d);
    int          nb;
    logic        ok;
    logic [31:0] v;
    req = r; we = w; addr = a; size = s; uns = u; wdata = d;
    @(posedge clk);
    e_rv = 1'b0; e_rd = 32'h0; e_mis = 1'b0;
    if (r && m_ready) begin
      nb = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
      ok = (s != 2'd3) && ((int'(a) % nb) == 0);
      if (!ok) begin
        e_mis = 1'b1;
      end else if (w) begin
        for (int i = 0; i < nb; i++) m_mem[int'(a) + i] = 8'((d >> (8 * i)) & 32'hFF);
      end else begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) v = v | (32'(m_mem[int'(a) + i]) << (8 * i));
        if (!u && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!u && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
        e_rv = 1'b1;
        e_rd = v;
      end
    end
    @(negedge clk);
    req = 1'b0;
    check("ready", 32'(ready), 32'(m_ready));
    check("rvalid", 32'(rvalid), 32'(e_rv));
    check("rdata", rdata, e_rd);
    check("misalign", 32'(misalign), 32'(e_mis));
  endtask

  // Counts cycles from release (at a negedge) until ready is seen high.
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    check(name, n, 16);
    model_clear();
    m_ready = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{0, 6'h3C, 2'd2, 0, 32'h0,         1, 32'h0000_0000, 0};
    tbl[1]  = '{1, 6'h10, 2'd2, 0, 32'h1234_5678, 0, 32'h0,         0};
    tbl[2]  = '{0, 6'h10, 2'd0, 1, 32'h0,         1, 32'h0000_0078, 0};
    tbl[3]  = '{0, 6'h11, 2'd0, 1, 32'h0,         1, 32'h0000_0056, 0};
    tbl[4]  = '{0, 6'h12, 2'd0, 1, 32'h0,         1, 32'h0000_0034, 0};
    tbl[5]  = '{0, 6'h13, 2'd0, 1, 32'h0,         1, 32'h0000_0012, 0};
    tbl[6]  = '{1, 6'h20, 2'd2, 0, 32'hAABB_CCDD, 0, 32'h0,         0};
    tbl[7]  = '{1, 6'h21, 2'd0, 0, 32'h0000_00F0, 0, 32'h0,         0};
    tbl[8]  = '{0, 6'h20, 2'd2, 0, 32'h0,         1, 32'hAABB_F0DD, 0};
    tbl[9]  = '{0, 6'h21, 2'd0, 0, 32'h0,         1, 32'hFFFF_FFF0, 0};
    tbl[10] = '{0, 6'h21, 2'd0, 1, 32'h0,         1, 32'h0000_00F0, 0};
    tbl[11] = '{1, 6'h30, 2'd2, 0, 32'h1111_2222, 0, 32'h0,         0};
    tbl[12] = '{1, 6'h32, 2'd1, 0, 32'h0000_8001, 0, 32'h0,         0};
    tbl[13] = '{0, 6'h32, 2'd1, 0, 32'h0,         1, 32'hFFFF_8001, 0};
    tbl[14] = '{0, 6'h30, 2'd1, 1, 32'h0,         1, 32'h0000_2222, 0};
    tbl[15] = '{1, 6'h04, 2'd2, 0, 32'hCAFE_BABE, 0, 32'h0,         0};
    tbl[16] = '{0, 6'h05, 2'd1, 0, 32'h0,         0, 32'h0,         1};
    tbl[17] = '{1, 6'h06, 2'd2, 0, 32'hDEAD_BEEF, 0, 32'h0,         1};
    tbl[18] = '{1, 6'h08, 2'd3, 0, 32'hFFFF_FFFF, 0, 32'h0,         1};
    tbl[19] = '{0, 6'h04, 2'd2, 0, 32'h0,         1, 32'hCAFE_BABE, 0};
    tbl[20] = '{0, 6'h08, 2'd2, 0, 32'h0,         1, 32'h0000_0000, 0};
    tbl[21] = '{0, 6'h00, 2'd3, 0, 32'h0,         0, 32'h0,         0};

    m_ready = 1'b0;
    model_clear();

    // Reset values and clear sweep length.
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    req = 1'b1;
    rst_n = 1'b1;
    wait_ready("clear_len");
    check("clear_no_rvalid", 32'(rvalid), 32'd0);
    req = 1'b0;

    // Directed vectors; the last entry is an idle cycle (req = 0).
    for (int i = 0; i < 22; i++) begin
      step(i != 21, tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns, tbl[i].wdata);
      check($sformatf("tbl%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].x_rv));
      check($sformatf("tbl%0d_rdata", i), rdata, tbl[i].x_rd);
      check($sformatf("tbl%0d_misalign", i), 32'(misalign), 32'(tbl[i].x_mis));
    end

    // Randomized traffic against the byte-array model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom), 6'($urandom), 2'($urandom),
           1'($urandom), $urandom);
    end

    // Load accepted on the edge where reset asserts: no rvalid survives.
    step(1'b1, 1'b1, 6'h10, 2'd2, 1'b0, 32'h5A5A_5A5A);
    req = 1'b1; we = 1'b0; addr = 6'h10; size = 2'd2; uns = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    req = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    check("rst_load_rvalid", 32'(rvalid), 32'd0);
    check("rst_load_rdata", rdata, 32'd0);
    check("rst_load_ready", 32'(ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of the sweep restarts it from word 0.
    repeat (7) @(negedge clk);
    check("mid_clear_ready", 32'(ready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("clear_restart_len");

    step(1'b1, 1'b0, 6'h10, 2'd2, 1'b0, 32'h0);
    step(1'b1, 1'b0, 6'h3C, 2'd2, 1'b0, 32'h0);
    check("post_clear_rdata", rdata, 32'h0);
    step(1'b1, 1'b1, 6'h3C, 2'd0, 1'b0, 32'h0000_0081);
    step(1'b1, 1'b0, 6'h3C, 2'd0, 1'b0, 32'h0);
    check("post_clear_sbyte", rdata, 32'hFFFF_FF81);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d checks, expected completion", n_checks);
    $fatal(1);
  end

endmodule
